// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  // Width of the in-flight request counter; bounds outstanding stale plus live requests.
  localparam int OUT_W = 8;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small register-based FIFO with occupancy count and synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues in-order imem requests, buffers
// returned instructions for decode and squashes stale responses on redirect.
module fetch_unit #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0]   pc;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  drop_cnt;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     tag_count;
  logic [CW:0]       used;
  logic [XLEN-1:0]   tag_head;
  fetch_entry_t      q_head;
  fetch_entry_t      q_push;
  logic              req_fire;
  logic              rsp_keep;
  logic              id_fire;

  // The tag queue holds exactly the live (non-stale) requests, so its count
  // equals outstanding - drop_cnt and completes the credit computation.
  assign used           = {1'b0, q_count} + {1'b0, tag_count};
  assign imem_req_valid = reset && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

  assign id_valid = (q_count != '0);
  assign id_fire  = id_valid && id_ready;
  assign id_pc    = q_head.pc;
  assign id_instr = q_head.instr;

  assign q_push.pc    = tag_head;
  assign q_push.instr = imem_rsp_data;

  fetch_queue #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_data_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (q_push),
    .pop       (id_fire),
    .head      (q_head),
    .count     (q_count)
  );

  fetch_queue #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_keep),
    .head      (tag_head),
    .count     (tag_count)
  );

  // req_fire is never set during a redirect, so the outstanding update is uniform.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        pc       <= redirect_pc & ~XLEN'(3);
        drop_cnt <= outstanding - OUT_W'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OUT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level memory and decode model.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } flight_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  flight_t     inflight[$];
  ent_t        mq[$];
  logic [31:0] exp_pc;
  int          cyc;
  int          last_due;
  int          checks;
  int          errors;
  int          p_ready, p_mready, p_redir, lat_min, lat_max;
  bit          force_redir;
  bit          redir_on_rsp;
  logic [31:0] force_target;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c_0f96;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    int      live;
    bit      exp_req;
    bit      req_fire;
    bit      id_fire;
    bit      keep;
    int      d;
    flight_t f;
    @(negedge clk);
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(inflight[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    id_ready       = ($urandom_range(99) < p_ready);
    imem_req_ready = ($urandom_range(99) < p_mready);
    if (redir_on_rsp && imem_rsp_valid) begin
      force_redir  = 1'b1;
      redir_on_rsp = 1'b0;
    end
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_target;
      force_redir    = 1'b0;
    end else if ($urandom_range(999) < p_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    #1;
    live = 0;
    foreach (inflight[i]) if (!inflight[i].stale) live++;
    exp_req = ((DEPTH - mq.size() - live) > 0) && !redirect_valid;
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("req_addr", imem_req_addr, exp_pc);
    chk("id_valid", id_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_instr", id_instr, mq[0].instr);
    end
    req_fire = exp_req && imem_req_ready;
    id_fire  = (mq.size() > 0) && id_ready;
    @(posedge clk);
    if (redirect_valid) begin
      if (imem_rsp_valid) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      mq.delete();
      exp_pc = redirect_pc & ~32'h3;
    end else begin
      keep = 1'b0;
      if (imem_rsp_valid) begin
        f    = inflight.pop_front();
        keep = !f.stale;
      end
      if (id_fire) void'(mq.pop_front());
      if (keep) mq.push_back('{pc: f.addr, instr: mem_word(f.addr)});
      if (req_fire) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        inflight.push_back('{addr: exp_pc, due: d, stale: 1'b0});
        exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_due = 0;
    force_redir = 0; redir_on_rsp = 0; force_target = '0;
    p_ready = 100; p_mready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    exp_pc = RPC;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // streaming with single-cycle memory
    run(12);
    // decode stall then release
    p_ready = 0;   run(10);
    p_ready = 100; run(8);
    // redirect with older requests still in a 3-cycle memory
    lat_min = 3; lat_max = 3;
    run(2);
    force_target = 32'h0000_0100; force_redir = 1; run(12);
    // redirect landing on the same cycle as a response
    force_target = 32'h0000_0100; redir_on_rsp = 1; run(12);
    redir_on_rsp = 0;
    // unaligned target near the top of the address space wraps
    lat_min = 1; lat_max = 1;
    force_target = 32'hFFFF_FFFE; force_redir = 1; run(8);
    // randomized traffic
    lat_min = 1; lat_max = 4; p_ready = 70; p_mready = 70; p_redir = 20;
    run(3000);

    // asynchronous reset between clock edges
    p_redir = 0; p_ready = 100; p_mready = 100; lat_min = 1; lat_max = 1;
    run(5);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req_valid", imem_req_valid, 1'b0);
    chk("mid_rst_id_valid", id_valid, 1'b0);
    chk("mid_rst_req_addr", imem_req_addr, RPC);
    inflight.delete(); mq.delete(); exp_pc = RPC; last_due = cyc;
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
